bitvector_sequencer: RTL

- Clocked controller that steps a static bit-vector stimulus through a programmed list of values, each held for a programmable number of cycles.
- Provides the same out/outb pair as the static bitvector source, so a testbench can swap one for the other.
- Programmed through a simple write port while idle; then started, stopped, run once or looped.

---
 rtl/bitvector_seq_pkg.sv | 19 +
 rtl/bitvector_seq_table.sv | 51 +++++
 rtl/bitvector_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/bitvector_seq_pkg.sv
// rtl/bitvector_seq_pkg.sv - shared state encoding and width helpers for the bit-vector sequencer
package bitvector_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // One extra bit so a full-table length (== depth) is representable.
    function automatic int len_width(input int depth);
        return idx_width(depth) + 1;
    endfunction

endpackage

// File: rtl/bitvector_seq_table.sv
// rtl/bitvector_seq_table.sv - value/hold register file with one write port and one async read port
module bitvector_seq_table
    import bitvector_seq_pkg::*;
#(
    parameter int bit_width = 1,
    parameter int depth     = 8,
    parameter int cnt_width = 8,
    parameter int idx_w     = idx_width(depth)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [idx_w-1:0]     wr_addr,
    input  logic [bit_width-1:0] wr_data,
    input  logic [cnt_width-1:0] wr_hold,
    input  logic [idx_w-1:0]     rd_addr,
    output logic [bit_width-1:0] rd_data,
    output logic [cnt_width-1:0] rd_hold
);

    logic [bit_width-1:0] value_q [depth];
    logic [bit_width-1:0] value_d [depth];
    logic [cnt_width-1:0] hold_q  [depth];
    logic [cnt_width-1:0] hold_d  [depth];

    always_comb begin
        value_d = value_q;
        hold_d  = hold_q;
        if (wr_en) begin
            value_d[wr_addr] = wr_data;
            hold_d[wr_addr]  = wr_hold;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < depth; i++) begin
                value_q[i] <= '0;
                hold_q[i]  <= '0;
            end
        end else begin
            value_q <= value_d;
            hold_q  <= hold_d;
        end
    end

    // Reads see the pre-write contents, so a same-edge write never leaks into a load.
    assign rd_data = value_q[rd_addr];
    assign rd_hold = hold_q[rd_addr];

endmodule

// File: rtl/bitvector_sequencer.sv
// rtl/bitvector_sequencer.sv - steps out/outb through a programmed value list with per-entry hold counts
module bitvector_sequencer
    import bitvector_seq_pkg::*;
#(
    parameter int                   bit_width  = 1,
    parameter int                   depth      = 8,
    parameter int                   cnt_width  = 8,
    parameter logic [bit_width-1:0] init_value = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [$clog2(depth)-1:0]   wr_addr,
    input  logic [bit_width-1:0]       wr_data,
    input  logic [cnt_width-1:0]       wr_hold,
    input  logic [$clog2(depth):0]     num_entries,
    input  logic                       loop,
    input  logic                       start,
    input  logic                       stop,
    output logic [bit_width-1:0]       out,
    output logic [bit_width-1:0]       outb,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(depth)-1:0]   idx,
    output logic                       wr_err
);

    localparam int IDX_W = idx_width(depth);
    localparam int LEN_W = len_width(depth);

    state_t               state_q, state_d;
    logic [bit_width-1:0] out_q, out_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [cnt_width-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic                 loop_q, loop_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 wr_err_q, wr_err_d;

    logic [IDX_W-1:0]     rd_addr;
    logic [bit_width-1:0] rd_data;
    logic [cnt_width-1:0] rd_hold;
    logic                 load;
    logic [LEN_W-1:0]     eff_len;

    bitvector_seq_table #(
        .bit_width (bit_width),
        .depth     (depth),
        .cnt_width (cnt_width),
        .idx_w     (IDX_W)
    ) u_table (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en && (state_q != RUN)),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_hold (wr_hold),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_hold (rd_hold)
    );

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        loop_d   = loop_q;
        rd_addr  = '0;
        load     = 1'b0;
        wr_err_d = wr_en && (state_q == RUN);
        eff_len  = (num_entries > LEN_W'(depth)) ? LEN_W'(depth) : num_entries;

        case (state_q)
            IDLE, DONE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (start && (num_entries != '0)) begin
                    state_d = RUN;
                    len_d   = eff_len;
                    loop_d  = loop;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - cnt_width'(1);
                end else if ({1'b0, idx_q} != (len_q - LEN_W'(1))) begin
                    rd_addr = idx_q + IDX_W'(1);
                    load    = 1'b1;
                end else if (loop_q) begin
                    load = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            idx_d = rd_addr;
            out_d = rd_data;
            cnt_d = rd_hold;
        end

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            out_q    <= init_value;
            idx_q    <= '0;
            cnt_q    <= '0;
            len_q    <= '0;
            loop_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            loop_q   <= loop_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign out    = out_q;
    assign outb   = ~out_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign idx    = idx_q;
    assign wr_err = wr_err_q;

endmodule
